// File: rtl/gsqrt_sched_if.sv
// Requester and engine signal bundle for the stochastic square-root scheduler.
// The master side drives requests, operands and the engine output bit.
interface gsqrt_sched_if #(
  parameter int NREQ = 4,
  parameter int BW   = 5,
  parameter int LW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*BW-1:0] val;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [LW:0]        res;
  logic               busy;
  logic               eng_rst_n;
  logic               eng_in;
  logic [BW-1:0]      eng_rand;
  logic               eng_out;

  modport master (
    output req, val, eng_out,
    input  grant, done, res, busy, eng_rst_n, eng_in, eng_rand
  );

  modport slave (
    input  req, val, eng_out,
    output grant, done, res, busy, eng_rst_n, eng_in, eng_rand
  );
endinterface

// File: rtl/gsqrt_sched.sv
// Round-robin scheduler sharing one stochastic square-root engine among NREQ
// requesters: stream generation, engine clear, burn-in and ones-count window.
//
// state | meaning
// IDLE  | engine out of reset, waiting for a request
// CLR   | engine held in reset for one cycle, LFSRs/counters reloaded
// BURN  | streams running, engine output ignored
// RUN   | streams running, engine output ones counted
// DONE  | done pulse to owner, result latched
module gsqrt_sched #(
  parameter int             NREQ   = 4,
  parameter int             BW     = 5,
  parameter int             BURN   = 16,
  parameter int             LW     = 8,
  parameter logic [BW-1:0]  TAPS_A = 5'b10100,
  parameter logic [BW-1:0]  TAPS_B = 5'b10010,
  parameter logic [BW-1:0]  SEED_A = 5'b00001,
  parameter logic [BW-1:0]  SEED_B = 5'b10101
) (
  input  logic clk,
  input  logic rst,
  gsqrt_sched_if.slave bus
);

  localparam int LEN  = 1 << LW;
  localparam int PMAX = (BURN > LEN) ? BURN : LEN;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [PW-1:0] BURN_TC = PW'(BURN - 1);
  localparam logic [PW-1:0] RUN_TC  = PW'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_BURN,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [LW:0]     res_q;
  logic            busy_q;
  logic            eng_rst_n_q;
  logic [BW-1:0]   op;
  logic [BW-1:0]   lfsr_a;
  logic [BW-1:0]   lfsr_b;
  logic [LW:0]     ones;
  logic [PW-1:0]   phase;
  logic [IW-1:0]   ptr;

  logic            any_req;
  logic [IW-1:0]   win;

  function automatic logic [BW-1:0] lfsr_step(input logic [BW-1:0] s,
                                              input logic [BW-1:0] taps);
    return {s[BW-2:0], ^(s & taps)};
  endfunction

  // First set request strictly after the last owner, wrapping around.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_req && bus.req[(int'(ptr) + k) % NREQ]) begin
        any_req = 1'b1;
        win     = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      eng_rst_n_q <= 1'b0;
      op          <= '0;
      lfsr_a      <= SEED_A;
      lfsr_b      <= SEED_B;
      ones        <= '0;
      phase       <= '0;
      ptr         <= IW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          eng_rst_n_q <= 1'b1;
          done_q      <= '0;
          if (any_req) begin
            grant_q     <= NREQ'(1) << win;
            op          <= bus.val[int'(win)*BW +: BW];
            ptr         <= win;
            busy_q      <= 1'b1;
            eng_rst_n_q <= 1'b0;
            state       <= S_CLR;
          end
        end
        S_CLR: begin
          eng_rst_n_q <= 1'b1;
          lfsr_a      <= SEED_A;
          lfsr_b      <= SEED_B;
          ones        <= '0;
          phase       <= '0;
          state       <= S_BURN;
        end
        S_BURN: begin
          lfsr_a <= lfsr_step(lfsr_a, TAPS_A);
          lfsr_b <= lfsr_step(lfsr_b, TAPS_B);
          if (phase == BURN_TC) begin
            phase <= '0;
            state <= S_RUN;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        S_RUN: begin
          lfsr_a <= lfsr_step(lfsr_a, TAPS_A);
          lfsr_b <= lfsr_step(lfsr_b, TAPS_B);
          ones   <= ones + (LW+1)'(bus.eng_out);
          if (phase == RUN_TC) begin
            done_q <= grant_q;
            state  <= S_DONE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        S_DONE: begin
          done_q  <= '0;
          res_q   <= ones;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.res       = res_q;
  assign bus.busy      = busy_q;
  assign bus.eng_rst_n = eng_rst_n_q;
  assign bus.eng_rand  = lfsr_b;
  assign bus.eng_in    = ((state == S_BURN) || (state == S_RUN)) && (op > lfsr_a);

endmodule

// File: tb/tb_gsqrt_sched.sv
// Bench for gsqrt_sched: directed job table, hand-written corner sequences and
// randomized jobs checked against a cycle-index reference of the job timeline.
module tb_gsqrt_sched;
  localparam int NREQ = 4;
  localparam int BW   = 5;
  localparam int BURN = 16;
  localparam int LW   = 8;
  localparam int LEN  = 1 << LW;
  localparam logic [BW-1:0] TAPS_A = 5'b10100;
  localparam logic [BW-1:0] TAPS_B = 5'b10010;
  localparam logic [BW-1:0] SEED_A = 5'b00001;
  localparam logic [BW-1:0] SEED_B = 5'b10101;
  localparam int PER      = (1 << BW) - 1;
  localparam int C_RUN0   = 2 + BURN;          // first RUN cycle after accept
  localparam int C_DONE   = 1 + BURN + LEN + 1;
  localparam int C_IDLE   = C_DONE + 1;
  localparam int NSTREAM  = BURN + LEN;

  logic clk;
  logic rst;

  gsqrt_sched_if #(.NREQ(NREQ), .BW(BW), .LW(LW)) bus ();

  gsqrt_sched #(
    .NREQ(NREQ), .BW(BW), .BURN(BURN), .LW(LW),
    .TAPS_A(TAPS_A), .TAPS_B(TAPS_B), .SEED_A(SEED_A), .SEED_B(SEED_B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [BW-1:0]   op;
    int              mode;     // 0 out=0, 1 out=1, 2 toggle, 3 random
    int              own;
    int              exp_res;  // -1: take the model's ones count
    int              rel;      // at done: 0 keep req, 1 drop owner, 2 drop all
    int              drop_at;
    bit              p2;
  } vec_t;

  vec_t tbl[12];
  int   n_chk;
  int   n_fail;
  int   ptr_m;
  int   prev_res;
  bit   have_ref;
  logic [BW-1:0] rseq_ref[NSTREAM+1];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] lfsr_next(input logic [BW-1:0] s,
                                              input logic [BW-1:0] taps);
    return {s[BW-2:0], ^(s & taps)};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic run_job(input int own, input logic [BW-1:0] opv, input int mode,
                         input int exp_res, input int rel, input int drop_at,
                         input bit p2, input int rst_at, input bit noise);
    int w;
    bit got;
    int ones;
    int ein_ones;
    int bad;
    int z;
    int mism;
    int want;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [NREQ-1:0] rr;
    bit ein[NSTREAM];
    logic [BW-1:0] rseq[NSTREAM+1];

    bus.val[own*BW +: BW] = opv;
    w = 0;
    got = 1'b0;
    while (!got && w < 20) begin
      step();
      w++;
      if (bus.grant != '0) got = 1'b1;
    end
    chk("accept_latency", w, 1);
    if (!got) return;
    ptr_m = own;
    a = SEED_A;
    b = SEED_B;
    ones = 0;
    ein_ones = 0;
    for (int c = 1; c <= C_IDLE; c++) begin
      if (c > 1) step();
      if (c == rst_at) begin
        rst = 1'b1;
        bus.req = '0;
        bus.eng_out = 1'b0;
        #1;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_res", int'(bus.res), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_eng_rst_n", int'(bus.eng_rst_n), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_res = 0;
        ptr_m = NREQ - 1;
        return;
      end
      chk("grant", int'(bus.grant), (c <= C_DONE) ? (1 << own) : 0);
      chk("busy", int'(bus.busy), (c <= C_DONE) ? 1 : 0);
      chk("done", int'(bus.done), (c == C_DONE) ? (1 << own) : 0);
      chk("eng_rst_n", int'(bus.eng_rst_n), (c != 1) ? 1 : 0);
      if (c >= 2 && c < C_DONE) begin
        chk("eng_in", int'(bus.eng_in), int'(opv > a));
        chk("eng_rand", int'(bus.eng_rand), int'(b));
        ein[c-2] = bus.eng_in;
        rseq[c-2] = bus.eng_rand;
        if (bus.eng_in) ein_ones++;
        a = lfsr_next(a, TAPS_A);
        b = lfsr_next(b, TAPS_B);
      end else begin
        chk("eng_in_off", int'(bus.eng_in), 0);
      end
      if (c == C_DONE) begin
        chk("eng_rand_hold", int'(bus.eng_rand), int'(b));
        rseq[NSTREAM] = bus.eng_rand;
      end
      want = (exp_res >= 0) ? exp_res : ones;
      chk("res", int'(bus.res), (c <= C_DONE) ? prev_res : want);
      case (mode)
        0: bus.eng_out = 1'b0;
        1: bus.eng_out = 1'b1;
        2: bus.eng_out = (c >= 2) && (c % 2 == 0);
        default: bus.eng_out = 1'($urandom_range(0, 1));
      endcase
      if (c >= C_IDLE) bus.eng_out = 1'b0;
      if (c >= C_RUN0 && c < C_DONE && bus.eng_out) ones++;
      if (noise && c >= 2 && c < C_DONE) begin
        rr = NREQ'($urandom);
        rr[own] = bus.req[own];
        bus.req = rr;
        bus.val = (NREQ*BW)'({$urandom, $urandom});
      end
      if (c == drop_at) bus.req[own] = 1'b0;
      if (c == C_DONE) begin
        if (rel == 1) bus.req[own] = 1'b0;
        if (rel == 2) bus.req = '0;
        if (p2) bus.req[2] = 1'b1;
      end
      if (c == C_IDLE && p2) bus.req[2] = 1'b0;
    end
    prev_res = (exp_res >= 0) ? exp_res : ones;
    if (opv == '0) chk("zero_stream_ones", ein_ones, 0);
    if (int'(opv) == PER) begin
      bad = 0;
      for (int s = 0; s + PER <= NSTREAM; s++) begin
        z = 0;
        for (int j = 0; j < PER; j++) if (!ein[s+j]) z++;
        if (z != 1) bad++;
      end
      chk("full_stream_windows", bad, 0);
    end
    if (have_ref) begin
      mism = 0;
      for (int i = 0; i <= NSTREAM; i++) if (rseq[i] !== rseq_ref[i]) mism++;
      chk("eng_rand_repeat", mism, 0);
    end else begin
      for (int i = 0; i <= NSTREAM; i++) rseq_ref[i] = rseq[i];
      have_ref = 1'b1;
    end
  endtask

  initial begin
    int own;
    logic [NREQ-1:0] r;
    logic [BW-1:0] opv;
    int drop;

    rst = 1'b1;
    bus.req = '0;
    bus.val = '0;
    bus.eng_out = 1'b0;
    n_chk = 0;
    n_fail = 0;
    ptr_m = NREQ - 1;
    prev_res = 0;
    have_ref = 1'b0;

    tbl[0]  = '{4'b1111, 5'd3,  2, 0, 128, 0, 0,  1'b0};
    tbl[1]  = '{4'b1111, 5'd12, 1, 1, 256, 0, 0,  1'b0};
    tbl[2]  = '{4'b1111, 5'd28, 0, 2, 0,   0, 0,  1'b0};
    tbl[3]  = '{4'b1111, 5'd7,  3, 3, -1,  0, 0,  1'b0};
    tbl[4]  = '{4'b1111, 5'd22, 1, 0, 256, 2, 0,  1'b0};
    tbl[5]  = '{4'b0001, 5'd9,  1, 0, 256, 1, 0,  1'b0};
    tbl[6]  = '{4'b0001, 5'd9,  0, 0, 0,   1, 0,  1'b0};
    tbl[7]  = '{4'b0001, 5'd17, 2, 0, 128, 1, 0,  1'b0};
    tbl[8]  = '{4'b0010, 5'd0,  3, 1, -1,  1, 0,  1'b0};
    tbl[9]  = '{4'b1000, 5'd31, 3, 3, -1,  1, 0,  1'b0};
    tbl[10] = '{4'b0001, 5'd20, 1, 0, 256, 1, C_RUN0 + 50, 1'b0};
    tbl[11] = '{4'b0001, 5'd5,  0, 0, 0,   1, 0,  1'b1};

    #3;
    chk("reset_grant", int'(bus.grant), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_res", int'(bus.res), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_eng_rst_n", int'(bus.eng_rst_n), 0);
    chk("reset_eng_rand", int'(bus.eng_rand), int'(SEED_B));
    chk("reset_eng_in", int'(bus.eng_in), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("idle_eng_rst_n", int'(bus.eng_rst_n), 1);
    chk("idle_grant", int'(bus.grant), 0);

    for (int i = 0; i < 12; i++) begin
      bus.req = tbl[i].req;
      run_job(tbl[i].own, tbl[i].op, tbl[i].mode, tbl[i].exp_res, tbl[i].rel,
              tbl[i].drop_at, tbl[i].p2, 0, 1'b0);
    end

    repeat (5) begin
      step();
      chk("idle_no_grant", int'(bus.grant), 0);
      chk("idle_res_hold", int'(bus.res), prev_res);
    end

    // Reset 100 cycles into RUN, then a fresh arbitration from requester 0.
    bus.req = 4'b0100;
    run_job(2, 5'd13, 1, -1, 1, 0, 1'b0, C_RUN0 + 100, 1'b0);
    step();
    chk("post_rst_grant", int'(bus.grant), 0);
    chk("post_rst_eng_rst_n", int'(bus.eng_rst_n), 1);
    chk("post_rst_res", int'(bus.res), 0);
    bus.req = 4'b1111;
    run_job(0, 5'd9, 1, 256, 2, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      opv = BW'($urandom);
      own = rr_pick(r, ptr_m);
      drop = ($urandom_range(0, 1) == 1) ? $urandom_range(C_RUN0, C_DONE - 2) : 0;
      bus.req = r;
      run_job(own, opv, 3, -1, 2, drop, 1'b0, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "time limit");
  end

endmodule
